// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer that gates the core's commit enable.
// Optional CYCLE_CNT_EN macro adds free-running cycle and retired-instruction counters.
module cpu_run_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_req_i,
    input  logic              halt_req_i,
    input  logic              halt_insn_i,
    input  logic              bp_en_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
    input  logic [ADDR_W-1:0] pc_value_i,
    output logic              cpu_en_o,
    output logic [1:0]        state_o,
    output logic              halted_o,
    output logic [1:0]        halt_cause_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_REQ  = 2'b01;
    localparam logic [1:0] C_BP   = 2'b10;
    localparam logic [1:0] C_INSN = 2'b11;

    state_t     state_q;
    logic [1:0] cause_q;
    logic       bp_skip_q;
    logic       bp_match;

    always_comb begin
        bp_match = bp_en_i && (pc_value_i == bp_addr_i) && !bp_skip_q;
    end

    always_comb begin
        cpu_en_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_RUN:   cpu_en_o = !halt_req_i && !bp_match;
                S_STEP:  cpu_en_o = 1'b1;
                default: cpu_en_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cause_q   <= C_NONE;
            bp_skip_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i)         state_q <= S_RUN;
                    else if (step_req_i) state_q <= S_STEP;
                end
                S_RUN: begin
                    if (bp_match) begin
                        state_q <= S_HALT;
                        cause_q <= C_BP;
                    end else if (halt_req_i) begin
                        state_q <= S_HALT;
                        cause_q <= C_REQ;
                    end else if (halt_insn_i) begin
                        state_q <= S_HALT;
                        cause_q <= C_INSN;
                    end
                    // The skip only needs to cover the one commit at the breakpoint PC.
                    if (cpu_en_o) bp_skip_q <= 1'b0;
                end
                S_STEP: begin
                    state_q <= S_HALT;
                    cause_q <= halt_insn_i ? C_INSN : C_REQ;
                end
                S_HALT: begin
                    if (start_i) begin
                        state_q   <= S_RUN;
                        cause_q   <= C_NONE;
                        bp_skip_q <= 1'b1;
                    end else if (step_req_i) begin
                        state_q <= S_STEP;
                        cause_q <= C_NONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o      = state_q;
    assign halted_o     = (state_q == S_HALT);
    assign halt_cause_o = cause_q;

`ifdef CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(state_q != S_IDLE);
        retired_cnt_d = retired_cnt_q + CNT_W'(cpu_en_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign retired_cnt_o = retired_cnt_q;
`else
    assign cycle_cnt_o   = '0;
    assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed scenarios followed by random stimulus,
// each cycle checked against a behavioural model of the run/halt/step rules.
module tb_cpu_run_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst, start, step_req, halt_req, halt_insn, bp_en;
    logic [ADDR_W-1:0] bp_addr, pc_value;
    logic              cpu_en, halted;
    logic [1:0]        state, halt_cause;
    logic [CNT_W-1:0]  cycle_cnt, retired_cnt;

    cpu_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .step_req_i   (step_req),
        .halt_req_i   (halt_req),
        .halt_insn_i  (halt_insn),
        .bp_en_i      (bp_en),
        .bp_addr_i    (bp_addr),
        .pc_value_i   (pc_value),
        .cpu_en_o     (cpu_en),
        .state_o      (state),
        .halted_o     (halted),
        .halt_cause_o (halt_cause),
        .cycle_cnt_o  (cycle_cnt),
        .retired_cnt_o(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int en;
        int st;
        int hl;
        int cause;
        int cyc;
        int ret;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: mode 0 idle, 1 run, 2 step, 3 halt; cause as reported.
    int m_mode  = 0;
    int m_cause = 0;
    int m_skip  = 0;
    int m_cyc   = 0;
    int m_ret   = 0;

    task automatic drive(input int r, input int s, input int stp, input int hr,
                         input int hi, input int be, input int ba, input int pc);
        exp_t e;
        int   hit;
        int   commit;
        @(posedge clk);
        #1;
        rst = r[0]; start = s[0]; step_req = stp[0]; halt_req = hr[0];
        halt_insn = hi[0]; bp_en = be[0];
        bp_addr = ADDR_W'(ba); pc_value = ADDR_W'(pc);

        hit    = (be != 0 && ba == pc && m_skip == 0) ? 1 : 0;
        commit = 0;
        if (r == 0) begin
            if (m_mode == 1 && hr == 0 && hit == 0) commit = 1;
            if (m_mode == 2) commit = 1;
        end
        e.en = commit; e.st = m_mode; e.hl = (m_mode == 3) ? 1 : 0; e.cause = m_cause;
`ifdef CYCLE_CNT_EN
        e.cyc = m_cyc; e.ret = m_ret;
`else
        e.cyc = 0; e.ret = 0;
`endif
        sb.push_back(e);

        if (r != 0) begin
            m_mode = 0; m_cause = 0; m_skip = 0; m_cyc = 0; m_ret = 0;
        end else begin
            if (m_mode != 0) m_cyc = (m_cyc + 1) % (1 << CNT_W);
            if (commit != 0) m_ret = (m_ret + 1) % (1 << CNT_W);
            if (m_mode == 0) begin
                if (s != 0) m_mode = 1;
                else if (stp != 0) m_mode = 2;
            end else if (m_mode == 1) begin
                if (commit != 0) m_skip = 0;
                if (hit != 0)          begin m_mode = 3; m_cause = 2; end
                else if (hr != 0)      begin m_mode = 3; m_cause = 1; end
                else if (hi != 0)      begin m_mode = 3; m_cause = 3; end
            end else if (m_mode == 2) begin
                m_mode = 3; m_cause = (hi != 0) ? 3 : 1;
            end else begin
                if (s != 0)        begin m_mode = 1; m_cause = 0; m_skip = 1; end
                else if (stp != 0) begin m_mode = 2; m_cause = 0; end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cpu_en",      32'(cpu_en),      e.en);
            chk("state",       32'(state),       e.st);
            chk("halted",      32'(halted),      e.hl);
            chk("halt_cause",  32'(halt_cause),  e.cause);
            chk("cycle_cnt",   32'(cycle_cnt),   e.cyc);
            chk("retired_cnt", 32'(retired_cnt), e.ret);
        end
    end

    initial begin
        int wait_cycles;
        rst = 1; start = 0; step_req = 0; halt_req = 0; halt_insn = 0; bp_en = 0;
        bp_addr = '0; pc_value = '0;

        // reset, then start
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        // breakpoint at 0xC, resume past it
        drive(0, 0, 0, 0, 0, 1, 'hC, 'h0);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'h4);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'h8);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'hC);
        drive(0, 1, 0, 0, 0, 1, 'hC, 'hC);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'hC);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'h10);
        drive(0, 0, 0, 0, 0, 1, 'hC, 'h14);
        // halt request, then single step
        drive(0, 0, 0, 1, 0, 1, 'hC, 'h18);
        drive(0, 0, 1, 0, 0, 0, 0, 'h18);
        drive(0, 0, 0, 0, 0, 0, 0, 'h18);
        drive(0, 0, 0, 0, 0, 0, 0, 'h1C);
        drive(0, 0, 0, 0, 0, 0, 0, 'h1C);
        // halt instruction, alone and with a concurrent halt request
        drive(0, 1, 0, 0, 0, 0, 0, 'h1C);
        drive(0, 0, 0, 0, 1, 0, 0, 'h20);
        drive(0, 1, 0, 0, 0, 0, 0, 'h24);
        drive(0, 0, 0, 1, 1, 0, 0, 'h24);
        drive(0, 0, 0, 0, 0, 0, 0, 'h24);
        // step onto a halt instruction, held step_req
        drive(0, 0, 1, 0, 0, 0, 0, 'h24);
        drive(0, 0, 1, 0, 1, 0, 0, 'h24);
        drive(0, 0, 1, 0, 0, 0, 0, 'h28);
        drive(0, 0, 1, 0, 0, 0, 0, 'h28);
        drive(0, 0, 0, 0, 0, 0, 0, 'h2C);
        // reset mid-run
        drive(0, 1, 0, 0, 0, 0, 0, 'h2C);
        drive(0, 0, 0, 0, 0, 0, 0, 'h30);
        drive(1, 0, 0, 0, 0, 0, 0, 'h34);
        drive(0, 0, 0, 0, 0, 0, 0, 'h0);
        // long run to wrap the 4-bit counters
        drive(0, 1, 0, 0, 0, 0, 0, 'h0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, i * 4);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0) ? 1 : 0,
                  ($urandom_range(99) < 10) ? 1 : 0,
                  ($urandom_range(99) < 10) ? 1 : 0,
                  ($urandom_range(99) < 8) ? 1 : 0,
                  ($urandom_range(99) < 8) ? 1 : 0,
                  int'($urandom_range(1)),
                  int'($urandom_range(7)) * 4,
                  int'($urandom_range(7)) * 4);
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
